// File: rtl/control_unit_mc.sv
// Multicycle Moore control unit for the HRM CPU: multi-channel I/O, SET/NOP opcodes,
// bounded I/O waits with a sticky fault, and burst single-step debug.
module control_unit_mc #(
  parameter int N_IN         = 2,
  parameter int N_OUT        = 2,
  parameter int WAIT_TIMEOUT = 0,
  parameter int STEP_W       = 4
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [7:0]        INSTR,
  input  logic [N_IN-1:0]   inEmpty,
  input  logic [N_OUT-1:0]  outFull,
  input  logic              debug,
  input  logic              nxtInstr,
  input  logic [STEP_W-1:0] step_n,
  output logic              wIR,
  output logic              wR,
  output logic              srcA,
  output logic              wM,
  output logic              wAR,
  output logic              wPC,
  output logic              ijump,
  output logic              branch,
  output logic              rst,
  output logic              halt,
  output logic [1:0]        muxR,
  output logic [2:0]        aluCtl,
  output logic [N_IN-1:0]   rIn,
  output logic [N_OUT-1:0]  wO,
  output logic              fault,
  output logic [4:0]        state_o
);

  localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  localparam logic [3:0] OP_INBOX    = 4'h0;
  localparam logic [3:0] OP_OUTBOX   = 4'h1;
  localparam logic [3:0] OP_COPYFROM = 4'h2;
  localparam logic [3:0] OP_COPYTO   = 4'h3;
  localparam logic [3:0] OP_ADD      = 4'h4;
  localparam logic [3:0] OP_SUB      = 4'h5;
  localparam logic [3:0] OP_BUMPP    = 4'h6;
  localparam logic [3:0] OP_BUMPN    = 4'h7;
  localparam logic [3:0] OP_JUMP     = 4'h8;
  localparam logic [3:0] OP_JUMPZ    = 4'h9;
  localparam logic [3:0] OP_JUMPN    = 4'hA;
  localparam logic [3:0] OP_NOP0     = 4'hB;
  localparam logic [3:0] OP_NOP1     = 4'hC;
  localparam logic [3:0] OP_NOP2     = 4'hD;
  localparam logic [3:0] OP_SET      = 4'hE;
  localparam logic [3:0] OP_HALT     = 4'hF;

  typedef enum logic [4:0] {
    S_RESET, S_FETCH_I, S_WAIT_KEY, S_LOAD_IR, S_DECODE,
    S_WAIT_INBOX, S_WAIT_OUTBOX, S_INBOX1, S_INBOX2, S_OUTBOX,
    S_INCPC2, S_FETCH_O, S_JUMP, S_JUMPZ, S_JUMPN, S_SET,
    S_LOAD_AR, S_READMEM2, S_LOAD_AR2, S_READMEM,
    S_COPYFROM, S_ADD, S_SUB, S_BUMPP, S_BUMPN, S_COPYTO,
    S_INC_PC, S_HALT, S_FAULT
  } state_t;

  state_t              state;
  logic [STEP_W-1:0]   burst;
  logic [CNT_W-1:0]    wait_cnt;
  logic                fault_q;

  logic [3:0] opcode;
  logic       ind;
  logic [2:0] ch;
  logic [7:0] in_empty_pad;
  logic [7:0] out_full_pad;
  logic       in_ok;
  logic       out_ok;
  logic       timeout_hit;

  assign opcode = INSTR[7:4];
  assign ind    = INSTR[3];
  assign ch     = INSTR[2:0];

  // Zero-padded flag vectors let a 3-bit channel index them for any N_IN/N_OUT
  assign in_empty_pad = 8'(inEmpty);
  assign out_full_pad = 8'(outFull);
  assign in_ok        = {29'd0, ch} < 32'(N_IN);
  assign out_ok       = {29'd0, ch} < 32'(N_OUT);
  assign timeout_hit  = (WAIT_TIMEOUT != 0) && (wait_cnt == CNT_W'(WAIT_TIMEOUT - 1));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_RESET;
      fault_q  <= 1'b0;
      burst    <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_RESET: state <= S_FETCH_I;
        S_FETCH_I: begin
          if (debug && burst == '0) begin
            state <= S_WAIT_KEY;
          end else begin
            if (debug) burst <= burst - 1'b1;
            state <= S_LOAD_IR;
          end
        end
        S_WAIT_KEY: begin
          if (nxtInstr) begin
            burst <= step_n;
            state <= S_LOAD_IR;
          end
        end
        S_LOAD_IR: state <= S_DECODE;
        S_DECODE: begin
          wait_cnt <= '0;
          case (opcode)
            OP_INBOX: begin
              if (!in_ok) begin
                state   <= S_FAULT;
                fault_q <= 1'b1;
              end else if (in_empty_pad[ch]) state <= S_WAIT_INBOX;
              else state <= S_INBOX1;
            end
            OP_OUTBOX: begin
              if (!out_ok) begin
                state   <= S_FAULT;
                fault_q <= 1'b1;
              end else if (out_full_pad[ch]) state <= S_WAIT_OUTBOX;
              else state <= S_OUTBOX;
            end
            OP_NOP0, OP_NOP1, OP_NOP2: state <= S_INC_PC;
            OP_HALT: state <= S_HALT;
            default: state <= S_INCPC2;
          endcase
        end
        // A flag clearing on the timeout cycle takes priority over the fault
        S_WAIT_INBOX: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (!in_empty_pad[ch]) state <= S_INBOX1;
          else if (timeout_hit) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
          end
        end
        S_WAIT_OUTBOX: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (!out_full_pad[ch]) state <= S_OUTBOX;
          else if (timeout_hit) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
          end
        end
        S_INBOX1: state <= S_INBOX2;
        S_INBOX2: state <= S_INC_PC;
        S_OUTBOX: state <= S_INC_PC;
        S_INCPC2: state <= S_FETCH_O;
        S_FETCH_O: begin
          case (opcode)
            OP_JUMP:  state <= S_JUMP;
            OP_JUMPZ: state <= S_JUMPZ;
            OP_JUMPN: state <= S_JUMPN;
            OP_SET:   state <= S_SET;
            default:  state <= S_LOAD_AR;
          endcase
        end
        S_JUMP, S_JUMPZ, S_JUMPN: state <= S_FETCH_I;
        S_SET: state <= S_INC_PC;
        S_LOAD_AR: begin
          if (opcode == OP_COPYTO && !ind) state <= S_COPYTO;
          else if (ind) state <= S_READMEM2;
          else state <= S_READMEM;
        end
        S_READMEM2: state <= S_LOAD_AR2;
        S_LOAD_AR2: state <= (opcode == OP_COPYTO) ? S_COPYTO : S_READMEM;
        S_READMEM: begin
          case (opcode)
            OP_COPYFROM: state <= S_COPYFROM;
            OP_ADD:      state <= S_ADD;
            OP_SUB:      state <= S_SUB;
            OP_BUMPP:    state <= S_BUMPP;
            OP_BUMPN:    state <= S_BUMPN;
            default: begin
              state   <= S_FAULT;
              fault_q <= 1'b1;
            end
          endcase
        end
        S_BUMPP, S_BUMPN: state <= S_COPYTO;
        S_COPYTO, S_ADD, S_SUB, S_COPYFROM: state <= S_INC_PC;
        S_INC_PC: state <= S_FETCH_I;
        S_HALT: state <= S_HALT;
        S_FAULT: begin
          state   <= S_FAULT;
          fault_q <= 1'b1;
        end
        default: begin
          state   <= S_FAULT;
          fault_q <= 1'b1;
        end
      endcase
      if (!debug) burst <= '0;
    end
  end

  always_comb begin
    wIR    = 1'b0;
    wR     = 1'b0;
    srcA   = 1'b0;
    wM     = 1'b0;
    wAR    = 1'b0;
    wPC    = 1'b0;
    ijump  = 1'b0;
    branch = 1'b0;
    rst    = 1'b0;
    halt   = 1'b0;
    muxR   = 2'b00;
    aluCtl = 3'b000;
    case (state)
      S_RESET:    rst = 1'b1;
      S_LOAD_IR:  wIR = 1'b1;
      S_INBOX2:   wR  = 1'b1;
      S_INCPC2:   wPC = 1'b1;
      S_INC_PC:   wPC = 1'b1;
      S_JUMP: begin
        branch = 1'b1;
        ijump  = 1'b1;
        wPC    = 1'b1;
      end
      S_JUMPZ: begin
        branch = 1'b1;
        wPC    = 1'b1;
      end
      S_JUMPN: begin
        branch = 1'b1;
        aluCtl = 3'b100;
        wPC    = 1'b1;
      end
      S_SET: begin
        muxR = 2'b10;
        wR   = 1'b1;
      end
      S_LOAD_AR:  wAR = 1'b1;
      S_LOAD_AR2: begin
        srcA = 1'b1;
        wAR  = 1'b1;
      end
      S_COPYFROM: begin
        muxR = 2'b01;
        wR   = 1'b1;
      end
      S_ADD: begin
        muxR = 2'b11;
        wR   = 1'b1;
      end
      S_SUB: begin
        muxR   = 2'b11;
        aluCtl = 3'b001;
        wR     = 1'b1;
      end
      S_BUMPP: begin
        muxR   = 2'b11;
        aluCtl = 3'b010;
        wR     = 1'b1;
      end
      S_BUMPN: begin
        muxR   = 2'b11;
        aluCtl = 3'b011;
        wR     = 1'b1;
      end
      S_COPYTO:        wM   = 1'b1;
      S_HALT, S_FAULT: halt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rIn = '0;
    wO  = '0;
    for (int i = 0; i < N_IN; i++)  rIn[i] = (state == S_INBOX1) && (ch == 3'(i));
    for (int i = 0; i < N_OUT; i++) wO[i]  = (state == S_OUTBOX) && (ch == 3'(i));
  end

  assign fault   = fault_q;
  assign state_o = state;

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: state walks, I/O wait timeout, bad channel,
// burst single-step and halt, with hand-derived expectations.
module tb_control_unit_mc;

  localparam int ST_RESET = 0, ST_FETCH_I = 1, ST_WAIT_KEY = 2, ST_LOAD_IR = 3, ST_DECODE = 4;
  localparam int ST_WAIT_OUTBOX = 6, ST_INBOX1 = 7, ST_INBOX2 = 8, ST_OUTBOX = 9;
  localparam int ST_INCPC2 = 10, ST_FETCH_O = 11, ST_JUMPN = 14, ST_SET = 15;
  localparam int ST_LOAD_AR = 16, ST_READMEM2 = 17, ST_LOAD_AR2 = 18, ST_READMEM = 19;
  localparam int ST_ADD = 21, ST_BUMPN = 24, ST_COPYTO = 25, ST_INC_PC = 26;
  localparam int ST_HALT = 27, ST_FAULT = 28;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] INSTR;
  logic [1:0] inEmpty, outFull;
  logic       debug, nxtInstr;
  logic [3:0] step_n;
  logic       wIR, wR, srcA, wM, wAR, wPC, ijump, branch, rst, halt, fault;
  logic [1:0] muxR, rIn, wO;
  logic [2:0] aluCtl;
  logic [4:0] state_o;

  int checks = 0;
  int errors = 0;
  int cnt;
  int pulses;

  always #5 clk = ~clk;

  control_unit_mc #(.N_IN(2), .N_OUT(2), .WAIT_TIMEOUT(5), .STEP_W(4)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .INSTR(INSTR), .inEmpty(inEmpty), .outFull(outFull),
    .debug(debug), .nxtInstr(nxtInstr), .step_n(step_n),
    .wIR(wIR), .wR(wR), .srcA(srcA), .wM(wM), .wAR(wAR), .wPC(wPC), .ijump(ijump),
    .branch(branch), .rst(rst), .halt(halt), .muxR(muxR), .aluCtl(aluCtl),
    .rIn(rIn), .wO(wO), .fault(fault), .state_o(state_o)
  );

  // Strobe order: wIR wR srcA wM wAR wPC ijump branch rst halt
  wire [9:0] strobes = {wIR, wR, srcA, wM, wAR, wPC, ijump, branch, rst, halt};

  task automatic applyStimulus(input logic [7:0] instr, input logic [1:0] ie, input logic [1:0] of,
                               input logic dbg, input logic [3:0] sn);
    INSTR   = instr;
    inEmpty = ie;
    outFull = of;
    debug   = dbg;
    step_n  = sn;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    i_rst_n = 1'b0;
    #1;
    checkOutput("rst_state", 32'(state_o), ST_RESET);
    checkOutput("rst_fault", 32'(fault), 0);
    checkOutput("rst_strobes", 32'(strobes), 'b0000000010);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    nxtInstr = 1'b0;
    applyStimulus(8'h01, 2'b00, 2'b00, 1'b0, 4'd0);
    i_rst_n = 1'b1;
    #1;
    resetPulse();
    checkOutput("rst_io", 32'({muxR, aluCtl, rIn, wO}), 0);

    // INBOX ch1, data ready
    tick(); checkOutput("in_fetch", 32'(state_o), ST_FETCH_I);
    tick(); checkOutput("in_loadir", 32'(state_o), ST_LOAD_IR);
    checkOutput("in_loadir_strb", 32'(strobes), 'b1000000000);
    tick(); checkOutput("in_decode", 32'(state_o), ST_DECODE);
    tick(); checkOutput("in_inbox1", 32'(state_o), ST_INBOX1);
    checkOutput("in_rin", 32'(rIn), 'b10);
    tick(); checkOutput("in_inbox2", 32'(state_o), ST_INBOX2);
    checkOutput("in_inbox2_strb", 32'(strobes), 'b0100000000);
    checkOutput("in_muxr", 32'(muxR), 0);
    checkOutput("in_rin_off", 32'(rIn), 0);
    tick(); checkOutput("in_incpc", 32'(state_o), ST_INC_PC);
    checkOutput("in_incpc_strb", 32'(strobes), 'b0000010000);
    tick(); checkOutput("in_back", 32'(state_o), ST_FETCH_I);

    // SET
    applyStimulus(8'hE0, 2'b00, 2'b00, 1'b0, 4'd0);
    tick(); tick();
    tick(); checkOutput("set_incpc2", 32'(state_o), ST_INCPC2);
    tick(); checkOutput("set_fetcho", 32'(state_o), ST_FETCH_O);
    tick(); checkOutput("set_state", 32'(state_o), ST_SET);
    checkOutput("set_strb", 32'(strobes), 'b0100000000);
    checkOutput("set_muxr", 32'(muxR), 'b10);
    tick(); checkOutput("set_incpc", 32'(state_o), ST_INC_PC);
    tick();

    // Indirect ADD
    applyStimulus(8'h48, 2'b00, 2'b00, 1'b0, 4'd0);
    tick(); tick(); tick(); tick();
    tick(); checkOutput("add_loadar", 32'(state_o), ST_LOAD_AR);
    checkOutput("add_loadar_strb", 32'(strobes), 'b0000100000);
    tick(); checkOutput("add_readmem2", 32'(state_o), ST_READMEM2);
    tick(); checkOutput("add_loadar2", 32'(state_o), ST_LOAD_AR2);
    checkOutput("add_loadar2_strb", 32'(strobes), 'b0010100000);
    tick(); checkOutput("add_readmem", 32'(state_o), ST_READMEM);
    tick(); checkOutput("add_state", 32'(state_o), ST_ADD);
    checkOutput("add_ctl", 32'({muxR, aluCtl}), 'b11000);
    checkOutput("add_strb", 32'(strobes), 'b0100000000);
    tick(); checkOutput("add_incpc", 32'(state_o), ST_INC_PC);
    tick();

    // Direct BUMP-
    applyStimulus(8'h70, 2'b00, 2'b00, 1'b0, 4'd0);
    tick(); tick(); tick(); tick(); tick();
    tick(); checkOutput("bmp_readmem", 32'(state_o), ST_READMEM);
    tick(); checkOutput("bmp_state", 32'(state_o), ST_BUMPN);
    checkOutput("bmp_ctl", 32'({muxR, aluCtl}), 'b11011);
    tick(); checkOutput("bmp_copyto", 32'(state_o), ST_COPYTO);
    checkOutput("bmp_copyto_strb", 32'(strobes), 'b0001000000);
    tick(); tick();

    // JUMPN returns straight to fetch
    applyStimulus(8'hA0, 2'b00, 2'b00, 1'b0, 4'd0);
    tick(); tick(); tick(); tick();
    tick(); checkOutput("jn_state", 32'(state_o), ST_JUMPN);
    checkOutput("jn_strb", 32'(strobes), 'b0000010100);
    checkOutput("jn_alu", 32'(aluCtl), 'b100);
    tick(); checkOutput("jn_back", 32'(state_o), ST_FETCH_I);

    // OUTBOX ch0 held full -> timeout fault after 5 wait cycles
    applyStimulus(8'h10, 2'b00, 2'b01, 1'b0, 4'd0);
    tick(); tick();
    tick(); checkOutput("to_wait", 32'(state_o), ST_WAIT_OUTBOX);
    cnt = 0;
    while (state_o == ST_WAIT_OUTBOX && cnt < 20) begin
      cnt++;
      tick();
    end
    checkOutput("to_cycles", cnt, 5);
    checkOutput("to_state", 32'(state_o), ST_FAULT);
    checkOutput("to_fault", 32'(fault), 1);
    checkOutput("to_strb", 32'(strobes), 'b0000000001);
    tick(); checkOutput("to_sticky", 32'({state_o, fault}), (ST_FAULT << 1) | 1);
    checkOutput("to_wo", 32'(wO), 0);
    resetPulse();

    // Flag clears on the exact timeout cycle
    tick();
    tick(); tick();
    tick(); tick(); tick(); tick(); tick();
    checkOutput("race_wait5", 32'(state_o), ST_WAIT_OUTBOX);
    outFull = 2'b00;
    tick(); checkOutput("race_outbox", 32'(state_o), ST_OUTBOX);
    checkOutput("race_wo", 32'(wO), 'b01);
    checkOutput("race_nofault", 32'(fault), 0);
    tick(); checkOutput("race_incpc", 32'(state_o), ST_INC_PC);
    tick();

    // INBOX channel 3 is out of range
    applyStimulus(8'h03, 2'b00, 2'b00, 1'b0, 4'd0);
    tick(); checkOutput("bad_rin_a", 32'(rIn), 0);
    tick(); checkOutput("bad_rin_b", 32'(rIn), 0);
    tick(); checkOutput("bad_state", 32'(state_o), ST_FAULT);
    checkOutput("bad_fault", 32'(fault), 1);
    checkOutput("bad_rin_c", 32'(rIn), 0);

    // Burst debug: step_n=2 -> 3 instructions per key press
    applyStimulus(8'hB0, 2'b00, 2'b00, 1'b1, 4'd2);
    resetPulse();
    tick(); tick(); checkOutput("dbg_waitkey", 32'(state_o), ST_WAIT_KEY);
    tick(); checkOutput("dbg_hold", 32'(state_o), ST_WAIT_KEY);
    nxtInstr = 1'b1;
    tick(); nxtInstr = 1'b0;
    checkOutput("dbg_loadir", 32'(state_o), ST_LOAD_IR);
    pulses = 0;
    cnt = 0;
    do begin
      tick();
      if (wPC) pulses++;
      cnt++;
    end while (state_o != ST_WAIT_KEY && cnt < 60);
    checkOutput("dbg3_reached", 32'(cnt < 60), 1);
    checkOutput("dbg3_wpc", pulses, 3);

    step_n = 4'd0;
    nxtInstr = 1'b1;
    tick(); nxtInstr = 1'b0;
    pulses = 0;
    cnt = 0;
    do begin
      tick();
      if (wPC) pulses++;
      cnt++;
    end while (state_o != ST_WAIT_KEY && cnt < 60);
    checkOutput("dbg1_reached", 32'(cnt < 60), 1);
    checkOutput("dbg1_wpc", pulses, 1);

    // HALT is absorbing and does not raise fault
    applyStimulus(8'hF0, 2'b00, 2'b00, 1'b0, 4'd0);
    resetPulse();
    tick(); tick(); tick();
    tick(); checkOutput("halt_state", 32'(state_o), ST_HALT);
    checkOutput("halt_strb", 32'(strobes), 'b0000000001);
    tick(); checkOutput("halt_stay", 32'(state_o), ST_HALT);
    checkOutput("halt_nofault", 32'(fault), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
